hit_statistic_multich: RTL and testbench
========================================

// Module: hit_statistic_multich
// PURPOSE
//  Multi-channel successor of the single-channel hit counter. Counts hits on NCH channels
//  over a window of a programmable number of tick periods, in single-shot or continuous mode.
//  Results go into snapshot registers with per-channel saturation flags.
//  Sits between the per-channel hit discriminators and the slow-control readout, in the
//  clk40M domain.
// PARAMETERS
//  NCH       8   number of hit channels
//  CNT_W     20  per-channel counter width (saturating)
//  WIN_W     8   width of window_ticks (window length in tick periods)
//  EDGE_MODE 0   0: count every cycle hit_r=1 (level); 1: count rising edges of hit_r only
// PORTS
//  clk40M       in   1            system clock, all logic on rising edge
//  reset_n      in   1            asynchronous active-low reset
//  start        in   1            level from slow control; rising edge arms a measurement
//  continuous   in   1            1 = re-arm automatically at window end (sampled at window end)
//  window_ticks in   WIN_W        window length in ticks, latched on start edge; 0 treated as 1
//  tick         in   1            1-cycle timebase pulse
//  hit          in   NCH          asynchronous-origin hit levels, already synchronized
//  busy         out  1            1 in ARM or COUNT
//  ready        out  1            snapshot valid (see below)
//  count_out    out  NCH*CNT_W    snapshot counts, channel i at [i*CNT_W +: CNT_W]
//  sat_out      out  NCH          snapshot saturation flag per channel
//  debug        out  1            1 while in COUNT
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; start_d, hit_r, hit_rr, live counters, tick_cnt,
//   win_len=1, busy=0, ready=0, count_out=0, sat_out=0. Reset mid-window discards it.
//  Input regs: start_d<=start; hit_r<=hit; hit_rr<=hit_r. start_edge = start & ~start_d.
//  inc[i] = hit_r[i] (EDGE_MODE=0) or hit_r[i] & ~hit_rr[i] (EDGE_MODE=1).
//  FSM:
//   IDLE/DONE: on start_edge -> ARM. Same edge: live counters=0, tick_cnt=0, ready=0,
//    win_len=max(window_ticks,1). A tick coincident with start_edge is not used.
//   ARM: on tick -> COUNT (tick_cnt=0). No counting in ARM.
//   COUNT: every cycle, live[i] += inc[i]; at all-ones live[i] holds and sat_live[i] sets.
//    On tick: if tick_cnt+1 == win_len the window ends, else tick_cnt++.
//    The cycle carrying the ending tick is still counted.
//   Window end (same edge): count_out <= live incl. this cycle's increment;
//    sat_out <= sat_live incl. this cycle; live, sat_live, tick_cnt cleared.
//    continuous=0: -> DONE, ready=1 (held until next start_edge or reset).
//    continuous=1: stay in COUNT, ready=1 for exactly one cycle; next window starts next cycle.
//  start_edge in ARM or COUNT is ignored. Deassert continuous to stop: the current window
//   completes, then -> DONE.
//  busy=1 in ARM/COUNT; debug=1 in COUNT. Outputs are registered. count_out and sat_out
//   change only at window end or reset.
//  Latency: first counted hit is the one at hit with hit_r sampled in the cycle after the
//   arming tick. Each hit is counted 1 cycle after it appears at the input (hit_r stage).
//  Counter arithmetic: unsigned CNT_W, +1 max per cycle per channel, no wrap-around.
//  window_ticks changes while busy have no effect.
// TESTING
//  1 win=1, EDGE_MODE=0, ch0 hit high 10 cycles inside window, others 0 -> count0=10, others 0,
//    ready=1, sat_out=0.
//  2 EDGE_MODE=1, ch3 toggles 0/1 for 7 pulses, win=2 ticks -> count3=7; steady-high ch5 -> count5=1.
//  3 CNT_W=4, ch1 held high 40 cycles -> count1=15, sat_out[1]=1; other channels unaffected.
//  4 continuous=1, win=1, ch2 high constant, tick period 100 -> ready pulses 1 cycle every 100,
//    each snapshot count2=100; drop continuous -> one more snapshot, then DONE with ready held.
//  5 start edge coincident with tick -> counting begins only after the next tick;
//    re-pulsing start while busy -> ignored, no restart.
//  6 reset_n low mid-COUNT -> all outputs 0 immediately (async), state IDLE;
//    window_ticks=0 -> behaves as 1.

Source files
------------

// File: rtl/hit_statistic_multich.sv
`timescale 1ns/1ps
// hit_statistic_multich
// Counts hits on NCH channels over a window of a programmable number of tick
// periods. Supports single-shot and continuous modes. Each window's result is
// stored in snapshot registers, together with a saturation flag per channel.
//
// Handshake: ready is a snapshot-valid flag with no back-pressure.
//  - Single-shot: ready rises at window end and stays high until the next
//    accepted start edge (or reset). While it is high, count_out and sat_out
//    are stable.
//  - Continuous: ready pulses for one cycle at each window end. count_out and
//    sat_out hold that snapshot until the following window end.
module hit_statistic_multich #(
  parameter int NCH       = 8,
  parameter int CNT_W     = 20,
  parameter int WIN_W     = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic                 clk40M,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [WIN_W-1:0]     window_ticks,
  input  logic                 tick,
  input  logic [NCH-1:0]       hit,
  output logic                 busy,
  output logic                 ready,
  output logic [NCH*CNT_W-1:0] count_out,
  output logic [NCH-1:0]       sat_out,
  output logic                 debug
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             start_d;
  logic [NCH-1:0]   hit_r, hit_rr;
  logic [NCH-1:0]   inc;
  logic [NCH-1:0]   sat_live, sat_nxt;
  logic [CNT_W-1:0] live     [NCH];
  logic [CNT_W-1:0] live_nxt [NCH];
  logic [WIN_W-1:0] tick_cnt, win_len;
  logic             start_edge, tick_last;
  logic             arm_go, win_end, ready_d;

  assign start_edge = start & ~start_d;
  assign inc        = (EDGE_MODE != 0) ? (hit_r & ~hit_rr) : hit_r;
  // Extra bit so win_len = all-ones still matches without wrapping.
  assign tick_last  = (({1'b0, tick_cnt} + {{WIN_W{1'b0}}, 1'b1}) == {1'b0, win_len});

  // Input staging: start edge detect and the hit pipeline used for edge mode.
  always_ff @(posedge clk40M or negedge reset_n) begin
    if (!reset_n) begin
      start_d <= 1'b0;
      hit_r   <= '0;
      hit_rr  <= '0;
    end else begin
      start_d <= start;
      hit_r   <= hit;
      hit_rr  <= hit_r;
    end
  end

  // Saturating next value of every live counter for this cycle's increment.
  always_comb begin
    sat_nxt = sat_live;
    for (int i = 0; i < NCH; i++) begin
      live_nxt[i] = live[i];
      if (inc[i]) begin
        if (&live[i]) sat_nxt[i] = 1'b1;
        else          live_nxt[i] = live[i] + CNT_W'(1);
      end
    end
  end

  // Next-state logic: arm on start edge, count between ticks, snapshot at window end.
  always_comb begin
    state_d = state_q;
    arm_go  = 1'b0;
    win_end = 1'b0;
    ready_d = ready;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d = S_ARM;
          arm_go  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_ARM: begin
        if (tick) state_d = S_COUNT;
      end
      S_COUNT: begin
        ready_d = 1'b0;
        if (tick && tick_last) begin
          win_end = 1'b1;
          ready_d = 1'b1;
          if (!continuous) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk40M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ready   <= 1'b0;
      busy    <= 1'b0;
      debug   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= ready_d;
      busy    <= (state_d == S_ARM) || (state_d == S_COUNT);
      debug   <= (state_d == S_COUNT);
    end
  end

  // Datapath: live counters, tick counter, window length and snapshot registers.
  always_ff @(posedge clk40M or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) live[i] <= '0;
      sat_live  <= '0;
      tick_cnt  <= '0;
      win_len   <= WIN_W'(1);
      count_out <= '0;
      sat_out   <= '0;
    end else if (arm_go) begin
      for (int i = 0; i < NCH; i++) live[i] <= '0;
      sat_live <= '0;
      tick_cnt <= '0;
      win_len  <= (window_ticks == '0) ? WIN_W'(1) : window_ticks;
    end else if (state_q == S_ARM) begin
      if (tick) tick_cnt <= '0;
    end else if (state_q == S_COUNT) begin
      if (win_end) begin
        for (int i = 0; i < NCH; i++) begin
          count_out[i*CNT_W +: CNT_W] <= live_nxt[i];
          live[i]                     <= '0;
        end
        sat_out  <= sat_nxt;
        sat_live <= '0;
        tick_cnt <= '0;
      end else begin
        for (int i = 0; i < NCH; i++) live[i] <= live_nxt[i];
        sat_live <= sat_nxt;
        if (tick) tick_cnt <= tick_cnt + WIN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hit_statistic_multich.sv
`timescale 1ns/1ps
// Bench for hit_statistic_multich: a level-mode and an edge-mode instance share
// one stimulus stream and are compared every cycle against a window-level model.
module tb_hit_statistic_multich;

  localparam int NCH = 8;
  localparam int WW  = 8;
  localparam int CW0 = 4;   // level-mode instance counter width
  localparam int CW1 = 5;   // edge-mode instance counter width

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, continuous = 1'b0, tick = 1'b0;
  logic [WW-1:0] window_ticks = 8'd1;
  logic [NCH-1:0] hit = '0;

  logic                 lvl_busy, lvl_ready, lvl_debug;
  logic [NCH*CW0-1:0]   lvl_count;
  logic [NCH-1:0]       lvl_sat;
  logic                 edg_busy, edg_ready, edg_debug;
  logic [NCH*CW1-1:0]   edg_count;
  logic [NCH-1:0]       edg_sat;

  hit_statistic_multich #(.NCH(NCH), .CNT_W(CW0), .WIN_W(WW), .EDGE_MODE(0)) dut_lvl (
    .clk40M(clk), .reset_n(rst_n), .start(start), .continuous(continuous),
    .window_ticks(window_ticks), .tick(tick), .hit(hit),
    .busy(lvl_busy), .ready(lvl_ready), .count_out(lvl_count), .sat_out(lvl_sat),
    .debug(lvl_debug));

  hit_statistic_multich #(.NCH(NCH), .CNT_W(CW1), .WIN_W(WW), .EDGE_MODE(1)) dut_edg (
    .clk40M(clk), .reset_n(rst_n), .start(start), .continuous(continuous),
    .window_ticks(window_ticks), .tick(tick), .hit(hit),
    .busy(edg_busy), .ready(edg_ready), .count_out(edg_count), .sat_out(edg_sat),
    .debug(edg_debug));

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts are kept as unbounded integers; the snapshot clips to the counter
  // maximum, and saturation means that some hit was lost.
  localparam int P_IDLE = 0, P_ARM = 1, P_COUNT = 2, P_DONE = 3;
  int             m_phase = P_IDLE;
  int             m_ticks = 0;
  int             m_wl = 1;
  bit             m_ready = 1'b0;
  bit             m_start_d = 1'b0;
  logic [NCH-1:0] m_hr = '0, m_hrr = '0;
  int unsigned    tot     [2][NCH];
  int unsigned    exp_cnt [2][NCH];
  bit             exp_sat [2][NCH];

  function automatic int unsigned cmax(input int k);
    return (k == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_ticks = 0; m_wl = 1; m_ready = 1'b0;
      m_start_d = 1'b0; m_hr = '0; m_hrr = '0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NCH; i++) begin
          tot[k][i] = 0; exp_cnt[k][i] = 0; exp_sat[k][i] = 1'b0;
        end
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start && !m_start_d) begin
            m_phase = P_ARM;
            m_ready = 1'b0;
            m_ticks = 0;
            m_wl    = (window_ticks == 0) ? 1 : int'(window_ticks);
            for (int k = 0; k < 2; k++)
              for (int i = 0; i < NCH; i++) tot[k][i] = 0;
          end
        end
        P_ARM: if (tick) m_phase = P_COUNT;
        default: begin
          m_ready = 1'b0;
          for (int i = 0; i < NCH; i++) begin
            if (m_hr[i]) tot[0][i]++;
            if (m_hr[i] && !m_hrr[i]) tot[1][i]++;
          end
          if (tick) begin
            m_ticks++;
            if (m_ticks == m_wl) begin
              for (int k = 0; k < 2; k++)
                for (int i = 0; i < NCH; i++) begin
                  exp_cnt[k][i] = (tot[k][i] > cmax(k)) ? cmax(k) : tot[k][i];
                  exp_sat[k][i] = (tot[k][i] > cmax(k));
                  tot[k][i] = 0;
                end
              m_ticks = 0;
              m_ready = 1'b1;
              if (!continuous) m_phase = P_DONE;
            end
          end
        end
      endcase
      m_start_d = start;
      m_hrr     = m_hr;
      m_hr      = hit;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NCH*CW0-1:0] e0;
  logic [NCH*CW1-1:0] e1;
  logic [NCH-1:0]     es0, es1;
  logic               m_busy, m_debug;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        e0[i*CW0 +: CW0] = CW0'(exp_cnt[0][i]);
        e1[i*CW1 +: CW1] = CW1'(exp_cnt[1][i]);
        es0[i] = exp_sat[0][i];
        es1[i] = exp_sat[1][i];
      end
      m_busy  = (m_phase == P_ARM) || (m_phase == P_COUNT);
      m_debug = (m_phase == P_COUNT);
      check("lvl_busy",  64'(lvl_busy),  64'(m_busy));
      check("lvl_ready", 64'(lvl_ready), 64'(m_ready));
      check("lvl_debug", 64'(lvl_debug), 64'(m_debug));
      check("lvl_count", 64'(lvl_count), 64'(e0));
      check("lvl_sat",   64'(lvl_sat),   64'(es0));
      check("edg_busy",  64'(edg_busy),  64'(m_busy));
      check("edg_ready", 64'(edg_ready), 64'(m_ready));
      check("edg_debug", 64'(edg_debug), 64'(m_debug));
      check("edg_count", 64'(edg_count), 64'(e1));
      check("edg_sat",   64'(edg_sat),   64'(es1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic t, input logic [NCH-1:0] h);
    tick = t;
    hit  = h;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic arm(input logic [WW-1:0] wt);
    window_ticks = wt;
    start = 1'b1;
    drive(1'b0, '0);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int pulses;
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy",  64'(lvl_busy),  64'd0);
    check("reset_ready", 64'(lvl_ready), 64'd0);
    check("reset_count", 64'(lvl_count), 64'd0);
    check("reset_sat",   64'(edg_sat),   64'd0);

    // Level counting, one-tick window, ch0 high for 10 counted cycles.
    arm(8'd1);
    drive(1'b1, '0);
    repeat (10) drive(1'b0, 8'h01);
    drive(1'b0, '0);
    drive(1'b1, '0);
    check("t1_ready",  64'(lvl_ready),        64'd1);
    check("t1_count0", 64'(lvl_count[3:0]),   64'd10);
    check("t1_others", 64'(lvl_count[31:4]),  64'd0);
    check("t1_sat",    64'(lvl_sat),          64'd0);
    check("t1_busy",   64'(lvl_busy),         64'd0);

    // Edge counting, two-tick window: ch3 pulses 7 times, ch5 held high.
    arm(8'd2);
    drive(1'b1, '0);
    for (int p = 0; p < 7; p++) begin
      drive(p == 3, 8'h28);
      drive(1'b0, 8'h20);
    end
    drive(1'b0, 8'h20);
    drive(1'b1, 8'h20);
    hit = '0;
    check("t2_edge_ch3", 64'(edg_count[3*CW1 +: CW1]), 64'd7);
    check("t2_edge_ch5", 64'(edg_count[5*CW1 +: CW1]), 64'd1);
    check("t2_edge_sat", 64'(edg_sat),                  64'd0);

    // Saturation of the 4-bit level counter.
    arm(8'd1);
    drive(1'b1, '0);
    repeat (40) drive(1'b0, 8'h02);
    drive(1'b1, 8'h02);
    hit = '0;
    check("t3_count1", 64'(lvl_count[7:4]), 64'd15);
    check("t3_count0", 64'(lvl_count[3:0]), 64'd0);
    check("t3_sat",    64'(lvl_sat),        64'h02);

    // Continuous mode, tick period 10, then stop.
    continuous = 1'b1;
    arm(8'd1);
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      if (c == 55) continuous = 1'b0;
      drive((c % 10) == 0, 8'h04);
      if (c < 59 && lvl_ready) begin
        pulses++;
        check("t4_snap_ch2", 64'(lvl_count[11:8]), 64'd10);
      end
    end
    hit = '0;
    check("t4_pulses",   64'(pulses),          64'd5);
    check("t4_ready",    64'(lvl_ready),       64'd1);
    check("t4_busy",     64'(lvl_busy),        64'd0);
    check("t4_last_ch2", 64'(lvl_count[11:8]), 64'd10);

    // Start coincident with tick, then a start re-pulse while counting.
    window_ticks = 8'd1;
    start = 1'b1;
    drive(1'b1, 8'h01);
    start = 1'b0;
    repeat (5) drive(1'b0, 8'h01);
    check("t5_still_arm", 64'({lvl_busy, lvl_debug}), 64'b10);
    drive(1'b1, 8'h01);
    drive(1'b0, 8'h01);
    start = 1'b1;
    drive(1'b0, 8'h01);
    start = 1'b0;
    drive(1'b0, 8'h01);
    drive(1'b1, 8'h01);
    check("t5_count0", 64'(lvl_count[3:0]), 64'd4);
    check("t5_ready",  64'(lvl_ready),      64'd1);

    // window_ticks = 0 acts as one tick.
    arm(8'd0);
    drive(1'b1, 8'h01);
    repeat (3) drive(1'b0, 8'h01);
    drive(1'b1, 8'h01);
    check("t6_win0_ready", 64'(lvl_ready),      64'd1);
    check("t6_win0_count", 64'(lvl_count[3:0]), 64'd4);

    // Asynchronous reset in the middle of a window.
    arm(8'd3);
    drive(1'b1, 8'h01);
    drive(1'b0, 8'h01);
    rst_n = 1'b0;
    #1;
    check("t6_rst_status", 64'({lvl_busy, lvl_ready, lvl_debug, edg_busy, edg_ready, edg_debug}), 64'd0);
    check("t6_rst_count",  64'({lvl_count, edg_count}), 64'd0);
    check("t6_rst_sat",    64'({lvl_sat, edg_sat}),     64'd0);
    hit = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 40) == 0) continuous = ~continuous;
      window_ticks = 8'($urandom_range(0, 3));
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        check("rnd_rst_count", 64'(lvl_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 4) == 0, 8'($urandom & $urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
